// File: rtl/rr_stream_arbiter.sv
// -----------------------------------------------------------------------------
// rr_stream_arbiter
//
// Round-robin arbiter that merges NumIn valid/ready streams into one sink.
// The winner is written into a two-entry spill stage (entry A fed from the
// inputs, entry B holding an overflow item while downstream stalls), so
// ready_o is computed from registered state and valid_i only. It never
// depends on ready_i.
//
// With LockIn=1, a requester that was selected but could not be accepted
// (buffer full) keeps the grant until it handshakes. This keeps the
// selection stable for an unchanged request.
//
// Ports
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   valid_i  : per-requester valid
//   ready_o  : per-requester ready, one-hot or zero
//   data_i   : payloads, requester k at [k*DataWidth +: DataWidth]
//   valid_o  : output valid
//   ready_i  : downstream ready
//   data_o   : output payload
//   idx_o    : requester index that supplied data_o
//
// Spill occupancy ({b_full_q, a_full_q})
//   state | meaning
//   00    | empty, output idle
//   01    | one item in A, A is shown on the output
//   10    | one item in B (A just drained or moved), B is shown
//   11    | two items, B is older and shown first; inputs are blocked
// -----------------------------------------------------------------------------
module rr_stream_arbiter #(
   parameter int unsigned  NumIn     = 4,
   parameter int unsigned  DataWidth = 32,
   parameter bit           LockIn    = 1'b1,
   localparam int unsigned IdxWidth  = $clog2(NumIn)
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [NumIn-1:0]           valid_i,
   output logic [NumIn-1:0]           ready_o,
   input  logic [NumIn*DataWidth-1:0] data_i,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [DataWidth-1:0]       data_o,
   output logic [IdxWidth-1:0]        idx_o
);

   logic [IdxWidth-1:0]  rr_q;
   logic                 lock_q;
   logic [IdxWidth-1:0]  lock_idx_q;

   logic                 a_full_q;
   logic                 b_full_q;
   logic [DataWidth-1:0] a_data_q;
   logic [DataWidth-1:0] b_data_q;
   logic [IdxWidth-1:0]  a_idx_q;
   logic [IdxWidth-1:0]  b_idx_q;

   logic [IdxWidth-1:0]  scan_idx;
   logic [IdxWidth:0]    cand_sum;
   logic                 found;
   logic [IdxWidth-1:0]  sel;
   logic                 any_valid;
   logic                 space;
   logic                 in_hs;
   logic                 a_to_b;

   logic [DataWidth-1:0] data_arr [NumIn];

   for (genvar g = 0; g < NumIn; g++) begin : g_unpack
      assign data_arr[g] = data_i[g*DataWidth +: DataWidth];
   end

   // ---------------------------------------------------------------------
   // Round-robin scan starting at rr_q. The candidate index is formed in
   // one extra bit so the wrap works for non-power-of-two NumIn as well.
   // ---------------------------------------------------------------------
   always_comb begin
      scan_idx = rr_q;
      cand_sum = '0;
      found    = 1'b0;
      for (int i = 0; i < NumIn; i++) begin
         cand_sum = {1'b0, rr_q} + (IdxWidth+1)'(i);
         if (cand_sum >= (IdxWidth+1)'(NumIn)) begin
            cand_sum = cand_sum - (IdxWidth+1)'(NumIn);
         end
         if (!found && valid_i[cand_sum[IdxWidth-1:0]]) begin
            found    = 1'b1;
            scan_idx = cand_sum[IdxWidth-1:0];
         end
      end
   end

   assign any_valid = |valid_i;
   assign space     = !(a_full_q && b_full_q);
   assign sel       = lock_q ? lock_idx_q : scan_idx;

   always_comb begin
      ready_o = '0;
      if (space && any_valid) begin
         ready_o[sel] = 1'b1;
      end
   end

   assign in_hs = |(valid_i & ready_o);

   // ---------------------------------------------------------------------
   // Grant pointer: moves just past the requester that handshook.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q <= '0;
      end else if (in_hs) begin
         rr_q <= (sel == IdxWidth'(NumIn-1)) ? '0 : sel + 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Lock-in: freeze the selection on a request that met a full buffer.
   // While locked, sel is lock_idx_q, so any handshake belongs to it.
   // ---------------------------------------------------------------------
   if (LockIn) begin : g_lock
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
         end else if (lock_q) begin
            if (in_hs) begin
               lock_q <= 1'b0;
            end
         end else if (valid_i[scan_idx] && !space) begin
            lock_q     <= 1'b1;
            lock_idx_q <= scan_idx;
         end
      end
   end else begin : g_no_lock
      assign lock_q     = 1'b0;
      assign lock_idx_q = '0;
   end

   // ---------------------------------------------------------------------
   // Spill stage. Whenever B is empty, A leaves in this cycle: either to
   // the output (ready_i=1) or into B (stall). A therefore stays occupied
   // only when both entries hold data. Then B is shown and space is 0.
   // ---------------------------------------------------------------------
   assign a_to_b = a_full_q && !b_full_q && !ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_full_q <= 1'b0;
         b_full_q <= 1'b0;
         a_data_q <= '0;
         b_data_q <= '0;
         a_idx_q  <= '0;
         b_idx_q  <= '0;
      end else begin
         a_full_q <= in_hs || (a_full_q && b_full_q);
         if (in_hs) begin
            a_data_q <= data_arr[sel];
            a_idx_q  <= sel;
         end

         if (b_full_q) begin
            b_full_q <= !ready_i;
         end else begin
            b_full_q <= a_to_b;
         end
         if (a_to_b) begin
            b_data_q <= a_data_q;
            b_idx_q  <= a_idx_q;
         end
      end
   end

   assign valid_o = a_full_q || b_full_q;
   assign data_o  = b_full_q ? b_data_q : a_data_q;
   assign idx_o   = b_full_q ? b_idx_q  : a_idx_q;

endmodule

// File: doc/rr_stream_arbiter.md
Name: rr_stream_arbiter

Overview:
Round-robin arbiter that shares one valid/ready stream sink among NumIn requesters. The output is registered through an internal two-entry spill stage. Ready towards the requesters therefore never depends combinationally on the downstream ready_i. It sits in front of shared datapaths such as interconnect ports and DMA queues, where several masters feed one consumer.

Parameters:
NumIn, 4, number of requesters (>=2)
DataWidth, 32, payload width per requester
LockIn, 1, 1 = hold arbitration on a presented-but-unaccepted request until it handshakes; 0 = re-arbitrate every cycle
IdxWidth, $clog2(NumIn), width of the grant index (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
valid_i  in  NumIn  per-requester valid
ready_o  out  NumIn  per-requester ready (one-hot or zero)
data_i  in  NumIn*DataWidth  payloads, requester k at bits [k*DataWidth +: DataWidth]
valid_o  out  1  output valid
ready_i  in  1  downstream ready
data_o  out  DataWidth  output payload
idx_o  out  IdxWidth  index of the requester that supplied data_o

Behaviour:
- Reset (async, rst_ni low): rr pointer = 0, lock cleared, both spill entries empty, stored data and index = 0.
- Outputs during reset: valid_o=0, data_o=0, idx_o=0.
- Selection: sel = first k with valid_i[k]=1, scanning rr_q, rr_q+1, ..., NumIn-1, 0, ..., rr_q-1 (wrap-around).
- space = !(entry A full && entry B full). Spill semantics: A fills from input; A moves to B when B is empty and the downstream is stalled; the output shows B if B is full, else A.
- ready_o[sel] = space && |valid_i. All other ready_o bits = 0. ready_o = 0 when no valid_i is set.
- Input handshake on k (valid_i[k] && ready_o[k]): {data_i[k], k} captured into A. rr_q <= (k+1) mod NumIn on the next edge.
- No handshake: rr_q is unchanged.
- Lock-in (LockIn=1): if valid_i[sel] && !space, lock_q=1 and lock_idx_q=sel. While locked, sel = lock_idx_q regardless of other valids or rr_q. The lock clears on the handshake of lock_idx_q.
- Requesters obey the stream rule (valid held until handshake), so locked valid never drops.
- LockIn=0: no lock state; sel is recomputed every cycle.
- Output: valid_o = A_full | B_full. data_o/idx_o = B if B_full, else A. Output handshake is valid_o && ready_i.
- Latency: input handshake at edge N gives valid_o from edge N (registered). This is one cycle later than the input valid cycle.
- Throughput: one transfer per cycle sustained when ready_i=1.
- With ready_i=0, at most two items are buffered; a third request sees ready_o=0.
- Simultaneous events:
  - Input fill and output drain in the same cycle are both honoured.
  - With A full and B empty, a fill plus a stall moves A to B while the new item lands in A. No item is lost or duplicated.
  - Order of output equals order of input handshakes.
- Reset mid-operation: buffered items are discarded, rr_q returns to 0, the lock is cleared, and valid_o falls asynchronously.
- Fairness: with all NumIn requesters continuously valid and ready_i=1, grants cycle 0,1,...,NumIn-1,0 with no requester granted twice before every other one has been granted once.

Test Plan:
- Single requester: valid_i=4'b0100, data 0xA5A5_0001, ready_i=1 -> ready_o=4'b0100; next cycle valid_o=1, data_o=0xA5A5_0001, idx_o=2; rr_q=3.
- All four valid constantly, ready_i=1, payload = 0x100+k -> idx_o sequence 0,1,2,3,0,1 at 1 item/cycle; data_o matches idx.
- Backpressure: all valid, ready_i=0 -> exactly two handshakes (idx 0, 1), then ready_o=0.
  - Requester 2 stays locked even when valid_i[0] reasserts.
  - Release ready_i -> outputs 0,1,2 in order, no loss or duplicate.
- Wrap-around: rr_q=3 after grant 2, valid_i=4'b1001 -> grant 3, then 0 -> idx_o 3 then 0.
- Simultaneous fill/drain: A full, B empty, ready_i toggling 1/0 every cycle with requester 1 streaming 0x10..0x1F -> data_o delivers 0x10..0x1F exactly once each, in order.
- Reset mid-operation: both entries full, assert rst_ni=0 asynchronously mid-cycle -> valid_o=0, data_o=0, idx_o=0 immediately. After release with valid_i=4'b1000 -> first grant idx 3 (scan from 0), lock cleared.
